cmac_stream_engine: RTL and testbench

CMAC_STREAM_ENGINE -- requirements
Module: cmac_stream_engine

---
 rtl/cmac_pkg.sv | 28 ++
 rtl/cmac_last_block.sv | 29 ++
 rtl/cmac_stream_engine.sv | 184 ++++++++++++++++++
 tb/tb_cmac_stream_engine.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmac_pkg.sv
// Shared types and constants for the AES-CMAC streaming engine.
// Holds the FSM state encoding, block width, Rb constant and pad byte.
package cmac_pkg;

  localparam int BLK_W = 128;
  localparam int BLK_B = BLK_W / 8;

  localparam logic [BLK_W-1:0] RB = 128'h87;
  localparam logic [7:0] PAD_BYTE = 8'h80;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SUBKEY,
    S_DERIVE,
    S_ABSORB,
    S_ENC,
    S_DONE
  } state_t;

  // Multiply-by-x in GF(2^128), used to derive K1/K2 from L.
  function automatic logic [BLK_W-1:0] dbl(
    input logic [BLK_W-1:0] v
  );
    return {v[BLK_W-2:0], 1'b0} ^
           (v[BLK_W-1] ? RB : '0);
  endfunction

endpackage

// File: rtl/cmac_last_block.sv
// Final-block conditioning: masks, pads and XORs K1/K2 into the block.
// Ports: i_block, i_rem_bytes (16 = complete), i_k1, i_k2 -> o_block.
module cmac_last_block
  import cmac_pkg::*;
(
  input  logic [BLK_W-1:0] i_block,
  input  logic [4:0]       i_rem_bytes,
  input  logic [BLK_W-1:0] i_k1,
  input  logic [BLK_W-1:0] i_k2,
  output logic [BLK_W-1:0] o_block
);

  logic [BLK_W-1:0] w_pad;

  // Keep bytes below rem, pad byte at rem, zero above.
  always_comb begin
    w_pad = '0;
    for (int i = 0; i < BLK_B; i++) begin
      if (5'(i) < i_rem_bytes)
        w_pad[BLK_W-1-8*i -: 8] = i_block[BLK_W-1-8*i -: 8];
      else if (5'(i) == i_rem_bytes)
        w_pad[BLK_W-1-8*i -: 8] = PAD_BYTE;
    end
  end

  assign o_block = (i_rem_bytes == 5'(BLK_B)) ?
                   (i_block ^ i_k1) : (w_pad ^ i_k2);

endmodule

// File: rtl/cmac_stream_engine.sv
// AES-CMAC engine driving an external AES core, with cached subkeys.
// Ports: start/rekey/mode/msg_len/tag_in job setup, msg_* block
// stream, aes_* core handshake, busy, tag_valid/tag/tag_match result.
module cmac_stream_engine
  import cmac_pkg::*;
#(
  parameter int LEN_W = 32,
  parameter int TAG_W = 128
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_start,
  input  logic             i_rekey,
  input  logic             i_mode,
  input  logic [LEN_W-1:0] i_msg_len,
  input  logic [TAG_W-1:0] i_tag_in,
  input  logic             i_msg_valid,
  output logic             o_msg_ready,
  input  logic [BLK_W-1:0] i_msg_data,
  output logic             o_aes_start,
  output logic [BLK_W-1:0] o_aes_din,
  input  logic [BLK_W-1:0] i_aes_dout,
  input  logic             i_aes_done,
  output logic             o_busy,
  output logic             o_tag_valid,
  output logic [TAG_W-1:0] o_tag,
  output logic             o_tag_match
);

  state_t r_state;
  state_t w_next;

  logic             r_keyvalid;
  logic             r_mode;
  logic [TAG_W-1:0] r_tag_in;
  logic [LEN_W-1:0] r_nblk;
  logic [LEN_W-1:0] r_cnt;
  logic [4:0]       r_rem;
  logic [BLK_W-1:0] r_x;
  logic [BLK_W-1:0] r_l;
  logic [BLK_W-1:0] r_k1;
  logic [BLK_W-1:0] r_k2;
  logic             r_aes_start;
  logic [BLK_W-1:0] r_aes_din;
  logic [TAG_W-1:0] r_tag;
  logic             r_match;

  logic             w_len_zero;
  logic [3:0]       w_tail;
  logic [LEN_W-1:0] w_nblk;
  logic [4:0]       w_rem;
  logic             w_need_key;
  logic             w_last;
  logic [BLK_W-1:0] w_blk_last;
  logic [BLK_W-1:0] w_blk;
  logic [BLK_W-1:0] w_d;
  logic [TAG_W-1:0] w_cand;

  assign w_len_zero = (i_msg_len == '0);
  assign w_tail     = i_msg_len[3:0];
  assign w_nblk     = w_len_zero ? LEN_W'(1) :
                      (i_msg_len >> 4) +
                      LEN_W'(w_tail != 4'd0);
  // rem = 16 flags a complete final block (K1 path).
  assign w_rem      = w_len_zero ? 5'd0 :
                      (w_tail == 4'd0) ? 5'd16 :
                      {1'b0, w_tail};
  assign w_need_key = i_rekey || !r_keyvalid;
  assign w_last     = (r_cnt == r_nblk - LEN_W'(1));
  assign w_blk      = w_last ? w_blk_last : i_msg_data;
  assign w_d        = r_x ^ w_blk;
  assign w_cand     = i_aes_dout[BLK_W-1 -: TAG_W];

  cmac_last_block u_last (
    .i_block     (i_msg_data),
    .i_rem_bytes (r_rem),
    .i_k1        (r_k1),
    .i_k2        (r_k2),
    .o_block     (w_blk_last)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:
        if (i_start)
          w_next = w_need_key ? S_SUBKEY : S_ABSORB;
      S_SUBKEY:
        if (i_aes_done) w_next = S_DERIVE;
      S_DERIVE:
        w_next = S_ABSORB;
      S_ABSORB:
        if (i_msg_valid) w_next = S_ENC;
      S_ENC:
        if (i_aes_done)
          w_next = w_last ? S_DONE : S_ABSORB;
      S_DONE:
        w_next = S_IDLE;
      default:
        w_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_msg_ready = (r_state == S_ABSORB);
    o_busy      = (r_state != S_IDLE);
    o_tag_valid = (r_state == S_DONE);
  end

  assign o_aes_start = r_aes_start;
  assign o_aes_din   = r_aes_din;
  assign o_tag       = r_tag;
  assign o_tag_match = r_match;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_keyvalid  <= 1'b0;
      r_mode      <= 1'b0;
      r_tag_in    <= '0;
      r_nblk      <= '0;
      r_cnt       <= '0;
      r_rem       <= '0;
      r_x         <= '0;
      r_l         <= '0;
      r_k1        <= '0;
      r_k2        <= '0;
      r_aes_start <= 1'b0;
      r_aes_din   <= '0;
      r_tag       <= '0;
      r_match     <= 1'b0;
    end else begin
      r_aes_start <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_mode   <= i_mode;
            r_tag_in <= i_tag_in;
            r_nblk   <= w_nblk;
            r_rem    <= w_rem;
            r_cnt    <= '0;
            r_x      <= '0;
            if (w_need_key) begin
              r_aes_start <= 1'b1;
              r_aes_din   <= '0;
            end
          end
        end
        S_SUBKEY: begin
          if (i_aes_done) r_l <= i_aes_dout;
        end
        S_DERIVE: begin
          r_k1       <= dbl(r_l);
          r_k2       <= dbl(dbl(r_l));
          r_keyvalid <= 1'b1;
        end
        S_ABSORB: begin
          if (i_msg_valid) begin
            r_aes_start <= 1'b1;
            r_aes_din   <= w_d;
          end
        end
        S_ENC: begin
          if (i_aes_done) begin
            r_x <= i_aes_dout;
            if (w_last) begin
              r_tag   <= w_cand;
              r_match <= r_mode && (w_cand == r_tag_in);
            end else begin
              r_cnt <= r_cnt + LEN_W'(1);
            end
          end
        end
        S_DONE: ;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cmac_stream_engine.sv
// Self-checking bench for cmac_stream_engine with a behavioural AES
// core and an RFC 4493 CMAC reference model.
module tb_cmac_stream_engine;

  localparam logic [127:0] KEY =
    128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [511:0] RFC_MSG = {
    128'h6bc1bee22e409f96e93d7e117393172a,
    128'hae2d8a571e03ac9c9eb76fac45af8e51,
    128'h30c81c46a35ce411e5fbc1191a0a52ef,
    128'hf69f2445df4f9b17ad2b417be66c3710};

  logic clk = 1'b0;
  logic reset;
  logic i_start, i_rekey, i_mode, i_msg_valid, i_aes_done;
  logic [31:0]  i_msg_len;
  logic [127:0] i_tag_in, i_msg_data, i_aes_dout;
  logic o_msg_ready, o_aes_start, o_busy, o_tag_valid;
  logic o_tag_match;
  logic [127:0] o_aes_din, o_tag;
  logic d_msg_ready, d_aes_start, d_busy, d_tag_valid;
  logic d_tag_match;
  logic [127:0] d_aes_din;
  logic [63:0]  d_tag;

  always #5 clk = ~clk;

  cmac_stream_engine u_dut (
    .clk(clk), .reset(reset),
    .i_start(i_start), .i_rekey(i_rekey), .i_mode(i_mode),
    .i_msg_len(i_msg_len), .i_tag_in(i_tag_in),
    .i_msg_valid(i_msg_valid), .o_msg_ready(o_msg_ready),
    .i_msg_data(i_msg_data), .o_aes_start(o_aes_start),
    .o_aes_din(o_aes_din), .i_aes_dout(i_aes_dout),
    .i_aes_done(i_aes_done), .o_busy(o_busy),
    .o_tag_valid(o_tag_valid), .o_tag(o_tag),
    .o_tag_match(o_tag_match));

  cmac_stream_engine #(.TAG_W(64)) u_dut64 (
    .clk(clk), .reset(reset),
    .i_start(i_start), .i_rekey(i_rekey), .i_mode(i_mode),
    .i_msg_len(i_msg_len), .i_tag_in(i_tag_in[127:64]),
    .i_msg_valid(i_msg_valid), .o_msg_ready(d_msg_ready),
    .i_msg_data(i_msg_data), .o_aes_start(d_aes_start),
    .o_aes_din(d_aes_din), .i_aes_dout(i_aes_dout),
    .i_aes_done(i_aes_done), .o_busy(d_busy),
    .o_tag_valid(d_tag_valid), .o_tag(d_tag),
    .o_tag_match(d_tag_match));

  int n_checks = 0;
  int n_errors = 0;
  int n_starts = 0;
  bit cached = 1'b0;
  logic [7:0] sbox_t [256];
  logic [7:0] msg_b [128];

  task automatic check(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a,
                                      input logic [7:0] b);
    logic [7:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xt(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [127:0] aes_enc(input logic [127:0] k,
                                           input logic [127:0] pt);
    logic [31:0] w [44];
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [31:0] tmp;
    logic [7:0] rc, a0, a1, a2, a3;
    logic [127:0] o;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sbox_t[tmp[23:16]], sbox_t[tmp[15:8]],
               sbox_t[tmp[7:0]], sbox_t[tmp[31:24]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++)
      s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int c = 0; c < 4; c++)
        for (int q = 0; q < 4; q++)
          t[q+4*c] = sbox_t[s[q+4*((c+q)%4)]];
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        if (r < 10) begin
          s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end else begin
          s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
        end
      end
      for (int i = 0; i < 16; i++)
        s[i] = s[i] ^ w[4*r+i/4][31-8*(i%4) -: 8];
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
    return o;
  endfunction

  function automatic logic [127:0] gf_dbl(input logic [127:0] v);
    return (v << 1) ^ (v[127] ? 128'h87 : 128'h0);
  endfunction

  // RFC 4493 CMAC over msg_b[0 .. len-1].
  function automatic logic [127:0] cmac_ref(input int len);
    logic [127:0] l, k1, k2, x, blk;
    int n, idx;
    bit complete;
    l  = aes_enc(KEY, 128'h0);
    k1 = gf_dbl(l);
    k2 = gf_dbl(k1);
    n = (len + 15) / 16;
    complete = (n != 0) && (len % 16 == 0);
    if (n == 0) n = 1;
    x = '0;
    for (int b = 0; b < n; b++) begin
      for (int j = 0; j < 16; j++) begin
        idx = b * 16 + j;
        if (idx < len)       blk[127-8*j -: 8] = msg_b[idx];
        else if (idx == len) blk[127-8*j -: 8] = 8'h80;
        else                 blk[127-8*j -: 8] = 8'h00;
      end
      if (b == n - 1) blk = blk ^ (complete ? k1 : k2);
      x = aes_enc(KEY, x ^ blk);
    end
    return x;
  endfunction

  // Behavioural AES core with a random 1..5 cycle latency.
  initial begin
    logic [127:0] din;
    i_aes_done = 1'b0;
    i_aes_dout = '0;
    forever begin
      @(negedge clk);
      if (o_aes_start && !reset) begin
        din = o_aes_din;
        n_starts++;
        repeat ($urandom_range(1, 5)) @(posedge clk);
        #1;
        i_aes_done = 1'b1;
        i_aes_dout = aes_enc(KEY, din);
        @(posedge clk);
        #1;
        i_aes_done = 1'b0;
        i_aes_dout = {4{$urandom}};
      end
    end
  end

  task automatic run_job(input string nm, input bit mode,
                         input bit rekey, input int len,
                         input logic [127:0] tin,
                         input logic [127:0] exp);
    int nblk, acc_n, cyc, s0, es, idx;
    bit acc;
    logic [127:0] blk;
    nblk = (len == 0) ? 1 : (len + 15) / 16;
    es = nblk + ((rekey || !cached) ? 1 : 0);
    cyc = 0;
    @(negedge clk);
    while (o_busy && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    @(posedge clk);
    #1;
    s0 = n_starts;
    i_start = 1'b1; i_rekey = rekey; i_mode = mode;
    i_msg_len = len; i_tag_in = tin;
    @(posedge clk);
    #1;
    i_start = 1'b0; i_rekey = 1'($urandom); i_mode = 1'($urandom);
    i_msg_len = $urandom; i_tag_in = {4{$urandom}};
    acc_n = 0;
    cyc = 0;
    while (acc_n < nblk && cyc < 3000) begin
      for (int j = 0; j < 16; j++) begin
        idx = acc_n * 16 + j;
        blk[127-8*j -: 8] = (idx < len) ? msg_b[idx] : 8'($urandom);
      end
      i_msg_data = blk;
      i_msg_valid = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      acc = o_msg_ready && i_msg_valid;
      @(posedge clk);
      #1;
      if (acc) acc_n++;
      cyc++;
    end
    i_msg_valid = 1'b0;
    cyc = 0;
    @(negedge clk);
    while (!o_tag_valid && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    check({nm, "/tag_valid"}, 128'(o_tag_valid), 128'd1);
    check({nm, "/tag"}, o_tag, exp);
    check({nm, "/match"}, 128'(o_tag_match),
          128'(mode && (tin == exp)));
    check({nm, "/tag64"}, 128'(d_tag), 128'(exp[127:64]));
    check({nm, "/match64"}, 128'(d_tag_match),
          128'(mode && (tin[127:64] == exp[127:64])));
    check({nm, "/aes_starts"}, 128'(n_starts - s0), 128'(es));
    @(negedge clk);
    check({nm, "/pulse"}, 128'(o_tag_valid), 128'd0);
    check({nm, "/idle"}, 128'(o_busy), 128'd0);
    check({nm, "/hold"}, o_tag, exp);
    cached = 1'b1;
  endtask

  initial begin
    logic [7:0] inv, b;
    logic [127:0] exp, tin;
    int len, acc_n, cyc;
    bit acc, mode, rekey, seen;

    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      b = inv;
      sbox_t[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^
                  {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    end
    for (int i = 0; i < 128; i++)
      msg_b[i] = (i < 64) ? RFC_MSG[511-8*i -: 8] : 8'h00;

    reset = 1'b1;
    i_start = 1'b0; i_rekey = 1'b0; i_mode = 1'b0;
    i_msg_len = '0; i_tag_in = '0;
    i_msg_valid = 1'b0; i_msg_data = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst/busy", 128'(o_busy), 128'd0);
    check("rst/ready", 128'(o_msg_ready), 128'd0);
    check("rst/aes_start", 128'(o_aes_start), 128'd0);
    check("rst/tag_valid", 128'(o_tag_valid), 128'd0);
    check("rst/tag_match", 128'(o_tag_match), 128'd0);
    check("rst/tag", o_tag, 128'd0);

    run_job("len0", 1'b0, 1'b1, 0, '0,
            128'hbb1d6929e95937287fa37d129b756746);
    run_job("len16", 1'b0, 1'b0, 16, '0,
            128'h070a16b46b4d4144f79bdd9dd04a287c);
    run_job("len40", 1'b0, 1'b0, 40, '0,
            128'hdfa66747de9ae63030ca32611497c827);
    run_job("ver_ok", 1'b1, 1'b0, 64,
            128'h51f0bebf7e3b9d92fc49741779363cfe,
            128'h51f0bebf7e3b9d92fc49741779363cfe);
    run_job("ver_bad", 1'b1, 1'b0, 64,
            128'h51f0bebf7e3b9d92fc49741779363cff,
            128'h51f0bebf7e3b9d92fc49741779363cfe);

    for (int k = 0; k < 6; k++) begin
      len = $urandom_range(0, 80);
      for (int i = 0; i < 128; i++) msg_b[i] = 8'($urandom);
      exp = cmac_ref(len);
      mode = 1'($urandom);
      rekey = ($urandom_range(0, 3) == 0);
      tin = exp;
      if ($urandom_range(0, 1) == 1)
        tin = exp ^ (128'h1 << $urandom_range(0, 127));
      run_job($sformatf("rnd%0d", k), mode, rekey, len, tin, exp);
    end

    // Abort a 4-block job while block index 2 is in the AES core.
    @(posedge clk);
    #1;
    i_start = 1'b1; i_rekey = 1'b0; i_mode = 1'b0; i_msg_len = 64;
    @(posedge clk);
    #1;
    i_start = 1'b0;
    acc_n = 0;
    cyc = 0;
    while (acc_n < 3 && cyc < 500) begin
      i_msg_data = {4{$urandom}};
      i_msg_valid = 1'b1;
      @(negedge clk);
      acc = o_msg_ready;
      @(posedge clk);
      #1;
      if (acc) acc_n++;
      cyc++;
    end
    i_msg_valid = 1'b0;
    check("abort/reached_enc", 128'(acc_n), 128'd3);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    cached = 1'b0;
    @(negedge clk);
    check("abort/busy", 128'(o_busy), 128'd0);
    check("abort/ready", 128'(o_msg_ready), 128'd0);
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (o_tag_valid || o_busy) seen = 1'b1;
    end
    check("abort/late_done", 128'(seen), 128'd0);

    for (int i = 0; i < 128; i++) msg_b[i] = 8'($urandom);
    exp = cmac_ref(33);
    run_job("post_rst", 1'b1, 1'b0, 33, exp, exp);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
